// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - shared encodings for the load/store memory controller
package lsu_mem_ctrl_pkg;

    localparam logic [1:0] CTL_WORD = 2'b00;
    localparam logic [1:0] CTL_RSVD = 2'b01;
    localparam logic [1:0] CTL_BYTE = 2'b10;
    localparam logic [1:0] CTL_HALF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // A request is rejected when its direction is ambiguous, its size is reserved,
    // or it is not naturally aligned for its size.
    function automatic logic req_is_fault(input logic rd, input logic wr,
                                          input logic [1:0] ctl, input logic [1:0] off);
        logic f;
        f = (rd == wr) || (ctl == CTL_RSVD);
        if (ctl == CTL_WORD && off != 2'b00) f = 1'b1;
        if (ctl == CTL_HALF && off[0])       f = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - big-endian lane select/sign-extend and lane merge
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  ctl,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    // Byte 0 of a word sits in the most significant lane (big-endian).
    always_comb begin
        load_data  = word;
        store_word = wdata;
        case (ctl)
            CTL_BYTE: begin
                case (offset)
                    2'b00: begin
                        load_data  = {{24{word[31]}}, word[31:24]};
                        store_word = {wdata[7:0], word[23:0]};
                    end
                    2'b01: begin
                        load_data  = {{24{word[23]}}, word[23:16]};
                        store_word = {word[31:24], wdata[7:0], word[15:0]};
                    end
                    2'b10: begin
                        load_data  = {{24{word[15]}}, word[15:8]};
                        store_word = {word[31:16], wdata[7:0], word[7:0]};
                    end
                    default: begin
                        load_data  = {{24{word[7]}}, word[7:0]};
                        store_word = {word[31:8], wdata[7:0]};
                    end
                endcase
            end
            CTL_HALF: begin
                if (offset[1]) begin
                    load_data  = {{16{word[15]}}, word[15:0]};
                    store_word = {word[31:16], wdata[15:0]};
                end else begin
                    load_data  = {{16{word[31]}}, word[31:16]};
                    store_word = {wdata[15:0], word[15:0]};
                end
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store initiator with sub-word RMW
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic [1:0]        Load_Control,
    input  logic [1:0]        Store_Control,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_Data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       Read_Data,
    output logic              fault,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state_q, state_n;
    logic [1:0]        off_q, ctl_q;
    logic [31:0]       wdata_q;
    logic              load_q;
    logic              resp_valid_n, fault_n, mem_re_n, mem_we_n;
    logic [31:0]       rdata_n, mem_wdata_n;
    logic [ADDR_W-3:0] mem_addr_n;
    logic [1:0]        req_ctl;
    logic              req_fault, accept;
    logic [31:0]       load_data, store_word;
    logic              unused_addr_hi;

    // Upper address bits do not reach memory, so accesses wrap.
    assign unused_addr_hi = ^Address[31:ADDR_W];

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_ready && req_valid;
    assign req_ctl   = Mem_Read ? Load_Control : Store_Control;
    assign req_fault = req_is_fault(Mem_Read, Mem_Write, req_ctl, Address[1:0]);

    // The old word read in RD feeds both the load extract and the store merge.
    lsu_lane_align u_lane_align (
        .word       (mem_rdata),
        .offset     (off_q),
        .ctl        (ctl_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n      = state_q;
        resp_valid_n = resp_valid;
        fault_n      = fault;
        rdata_n      = Read_Data;
        mem_wdata_n  = mem_wdata;
        mem_addr_n   = mem_addr;
        mem_re_n     = 1'b0;
        mem_we_n     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rdata_n    = '0;
                    fault_n    = 1'b0;
                    mem_addr_n = Address[ADDR_W-1:2];
                    if (req_fault) begin
                        state_n      = ST_DONE;
                        resp_valid_n = 1'b1;
                        fault_n      = 1'b1;
                    end else if (Mem_Read || Store_Control != CTL_WORD) begin
                        state_n  = ST_RD;
                        mem_re_n = 1'b1;
                    end else begin
                        state_n     = ST_WR;
                        mem_we_n    = 1'b1;
                        mem_wdata_n = Write_Data;
                    end
                end
            end
            ST_RD: begin
                if (load_q) begin
                    rdata_n      = load_data;
                    resp_valid_n = 1'b1;
                    state_n      = ST_DONE;
                end else begin
                    mem_wdata_n = store_word;
                    mem_we_n    = 1'b1;
                    state_n     = ST_WR;
                end
            end
            ST_WR: begin
                resp_valid_n = 1'b1;
                state_n      = ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    state_n      = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access at once.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            Read_Data  <= '0;
            mem_wdata  <= '0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            state_q    <= state_n;
            resp_valid <= resp_valid_n;
            fault      <= fault_n;
            Read_Data  <= rdata_n;
            mem_wdata  <= mem_wdata_n;
            mem_addr   <= mem_addr_n;
            mem_re     <= mem_re_n;
            mem_we     <= mem_we_n;
        end
    end

    // Request fields captured at accept for use by the later access phases.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            off_q   <= '0;
            ctl_q   <= CTL_WORD;
            wdata_q <= '0;
            load_q  <= 1'b0;
        end else if (accept) begin
            off_q   <= Address[1:0];
            ctl_q   <= req_ctl;
            wdata_q <= Write_Data;
            load_q  <= Mem_Read;
        end
    end

endmodule
